// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence path (generator and detectors).
package seq_pkg;

  localparam int unsigned PAT_W_DEF = 8;
  localparam int unsigned LEN_W_DEF = 4;
  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned GAP_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/seq_down_cnt.sv
// Loadable down-counter that saturates at zero and flags the zero value.
module seq_down_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  // Load has priority over decrement; decrement never wraps below zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= W'(count - W'(1));
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial bit-pattern transmitter: sends a captured pattern MSB-first, repeated with gaps.
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int unsigned PAT_W = PAT_W_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned GAP_W = GAP_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [GAP_W-1:0] gap,
  output logic             t,
  output logic             t_valid,
  output logic             first,
  output logic             busy,
  output logic             done
);

  seq_state_e       state;
  logic [PAT_W-1:0] pattern_q;
  logic [LEN_W-1:0] len_q;
  logic [GAP_W-1:0] gap_q;

  logic [LEN_W-1:0] bit_cnt;
  logic             bit_zero;
  logic             frame_zero;
  logic             gap_zero;
  logic [CNT_W-1:0] frame_cnt_unused;
  logic [GAP_W-1:0] gap_cnt_unused;

  logic             bit_load_c, bit_dec_c;
  logic [LEN_W-1:0] bit_val_c;
  logic             frame_load_c, frame_dec_c;
  logic [CNT_W-1:0] frame_val_c;
  logic             gap_load_c, gap_dec_c;
  logic [GAP_W-1:0] gap_val_c;
  logic [LEN_W-1:0] len_c;
  logic             go_c;
  logic             start_bit_c, cur_bit_c, restart_bit_c;

  // Single-bit select with a runtime index, written as a mask so every bit is read.
  function automatic logic bit_sel(input logic [PAT_W-1:0] v, input logic [LEN_W-1:0] idx);
    return |(v & (PAT_W'(1) << idx));
  endfunction

  // Length clamp, bit selection and counter control derived from the current state.
  always_comb begin
    bit_load_c   = 1'b0;
    bit_dec_c    = 1'b0;
    bit_val_c    = '0;
    frame_load_c = 1'b0;
    frame_dec_c  = 1'b0;
    frame_val_c  = '0;
    gap_load_c   = 1'b0;
    gap_dec_c    = 1'b0;
    gap_val_c    = '0;
    len_c         = (pat_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : pat_len;
    go_c          = start && !abort;
    start_bit_c   = bit_sel(pattern, LEN_W'(len_c - LEN_W'(1)));
    cur_bit_c     = bit_sel(pattern_q, LEN_W'(bit_cnt - LEN_W'(1)));
    restart_bit_c = bit_sel(pattern_q, LEN_W'(len_q - LEN_W'(1)));
    case (state)
      ST_IDLE: begin
        if (go_c && (len_c != '0) && (repeat_n != '0)) begin
          bit_load_c   = 1'b1;
          bit_val_c    = LEN_W'(len_c - LEN_W'(1));
          frame_load_c = 1'b1;
          frame_val_c  = CNT_W'(repeat_n - CNT_W'(1));
        end
      end
      ST_SHIFT: begin
        if (!bit_zero) begin
          bit_dec_c = 1'b1;
        end else if (!frame_zero) begin
          frame_dec_c = 1'b1;
          if (gap_q != '0) begin
            gap_load_c = 1'b1;
            gap_val_c  = GAP_W'(gap_q - GAP_W'(1));
          end else begin
            bit_load_c = 1'b1;
            bit_val_c  = LEN_W'(len_q - LEN_W'(1));
          end
        end
      end
      ST_GAP: begin
        if (!gap_zero) begin
          gap_dec_c = 1'b1;
        end else begin
          bit_load_c = 1'b1;
          bit_val_c  = LEN_W'(len_q - LEN_W'(1));
        end
      end
      default: ;
    endcase
  end

  // State register, captured transfer parameters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pattern_q <= '0;
      len_q     <= '0;
      gap_q     <= '0;
      t         <= 1'b0;
      t_valid   <= 1'b0;
      first     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      t       <= 1'b0;
      t_valid <= 1'b0;
      first   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (go_c) begin
            pattern_q <= pattern;
            len_q     <= len_c;
            gap_q     <= gap;
            if ((len_c == '0) || (repeat_n == '0)) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state   <= ST_SHIFT;
              t       <= start_bit_c;
              t_valid <= 1'b1;
              first   <= 1'b1;
              busy    <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (!bit_zero) begin
            t       <= cur_bit_c;
            t_valid <= 1'b1;
            busy    <= 1'b1;
          end else if (frame_zero) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else if (gap_q != '0) begin
            state <= ST_GAP;
            busy  <= 1'b1;
          end else begin
            t       <= restart_bit_c;
            t_valid <= 1'b1;
            first   <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ST_GAP: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (gap_zero) begin
            state   <= ST_SHIFT;
            t       <= restart_bit_c;
            t_valid <= 1'b1;
            first   <= 1'b1;
            busy    <= 1'b1;
          end else begin
            busy <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Index of the bit currently on t.
  seq_down_cnt #(.W(LEN_W)) u_bit_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (bit_load_c),
    .dec      (bit_dec_c),
    .load_val (bit_val_c),
    .count    (bit_cnt),
    .zero     (bit_zero)
  );

  // Frames still to send after the current one.
  seq_down_cnt #(.W(CNT_W)) u_frame_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (frame_load_c),
    .dec      (frame_dec_c),
    .load_val (frame_val_c),
    .count    (frame_cnt_unused),
    .zero     (frame_zero)
  );

  // Gap cycles still to wait after the current one.
  seq_down_cnt #(.W(GAP_W)) u_gap_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (gap_load_c),
    .dec      (gap_dec_c),
    .load_val (gap_val_c),
    .count    (gap_cnt_unused),
    .zero     (gap_zero)
  );

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench for seq_pattern_gen against a per-cycle behavioural model.
module tb_seq_pattern_gen;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] pattern;
  logic [3:0] pat_len;
  logic [7:0] repeat_n;
  logic [3:0] gap;
  logic       t;
  logic       t_valid;
  logic       first;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;
  bit rx_q[$];

  seq_pattern_gen dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .pattern  (pattern),
    .pat_len  (pat_len),
    .repeat_n (repeat_n),
    .gap      (gap),
    .t        (t),
    .t_valid  (t_valid),
    .first    (first),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  function automatic logic [4:0] obs();
    return {t, t_valid, first, busy, done};
  endfunction

  // One transfer: expected per-cycle outputs {t,t_valid,first,busy,done} from cycle 1 on.
  task automatic run_xfer(input logic [7:0] pat, input logic [3:0] len, input logic [7:0] rep,
                          input logic [3:0] gp, input int abort_at, input bit noise,
                          input string name);
    logic [4:0] exp_q[$];
    logic [4:0] got;
    int eff;
    eff = (len > 4'd8) ? 8 : int'(len);
    if (eff == 0 || rep == 8'd0) begin
      exp_q.push_back(5'b00001);
    end else begin
      for (int f = 0; f < int'(rep); f++) begin
        for (int b = eff - 1; b >= 0; b--)
          exp_q.push_back({pat[b], 1'b1, (b == eff - 1), 1'b1, 1'b0});
        if (f < int'(rep) - 1)
          for (int g = 0; g < int'(gp); g++) exp_q.push_back(5'b00010);
      end
      exp_q.push_back(5'b00001);
    end
    exp_q.push_back(5'b00000);
    rx_q.delete();

    @(negedge clk);
    pattern = pat; pat_len = len; repeat_n = rep; gap = gp; start = 1'b1; abort = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      got = obs();
      if (t_valid) rx_q.push_back(t);
      n_tests++;
      if (got !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got {t,v,first,busy,done}=%b expected %b",
                 name, i + 1, got, exp_q[i]);
      end
      start = 1'b0; abort = 1'b0;
      if (noise) begin
        pattern = 8'($urandom); pat_len = 4'($urandom);
        repeat_n = 8'($urandom); gap = 4'($urandom);
      end
      if (i == abort_at && i < exp_q.size() - 1) begin
        abort = 1'b1;
        while (exp_q.size() > i + 1) void'(exp_q.pop_back());
        exp_q.push_back(5'b00000);
      end else if (noise && i < exp_q.size() - 1) begin
        start = 1'($urandom_range(0, 1));
      end
    end
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    pattern = '0; pat_len = '0; repeat_n = '0; gap = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (obs() !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_hold: got %b expected 00000", obs());
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (obs() !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_release: got %b expected 00000", obs());
    end
  endtask

  task automatic test_single_frame();
    run_xfer(8'h0A, 4'd4, 8'd1, 4'd0, -1, 1'b0, "single_frame");
  endtask

  task automatic test_gap_repeat();
    run_xfer(8'h0A, 4'd4, 8'd3, 4'd2, -1, 1'b0, "gap_repeat");
  endtask

  // Non-overlapping 1010 detector fed with the t_valid-gated stream.
  task automatic test_loopback();
    int y, since;
    logic [3:0] w;
    run_xfer(8'h0A, 4'd4, 8'd3, 4'd0, -1, 1'b0, "loopback");
    y = 0; since = 0; w = '0;
    foreach (rx_q[k]) begin
      w = {w[2:0], rx_q[k]};
      since++;
      if (since >= 4 && w == 4'b1010) begin y++; since = 0; end
    end
    n_tests++;
    if (y !== 3) begin
      n_fail++;
      $display("FAIL loopback_detect: got %0d detections expected 3", y);
    end
  endtask

  task automatic test_boundaries();
    int ones;
    run_xfer(8'h0A, 4'd0, 8'd5, 4'd1, -1, 1'b0, "zero_len");
    run_xfer(8'h0A, 4'd4, 8'd0, 4'd2, -1, 1'b0, "zero_repeat");
    run_xfer(8'hFF, 4'd15, 8'd1, 4'd0, -1, 1'b0, "clamp_len");
    ones = 0;
    foreach (rx_q[k]) if (rx_q[k]) ones++;
    n_tests++;
    if (ones !== 8) begin
      n_fail++;
      $display("FAIL clamp_ones: got %0d ones expected 8", ones);
    end
    run_xfer(8'h01, 4'd1, 8'd255, 4'd0, -1, 1'b0, "max_repeat");
  endtask

  task automatic test_abort();
    run_xfer(8'h0A, 4'd4, 8'd1, 4'd0, 2, 1'b0, "abort");
    @(posedge clk); #1;
    n_tests++;
    if (obs() !== 5'b0) begin
      n_fail++;
      $display("FAIL abort_idle: got %b expected 00000", obs());
    end
    run_xfer(8'h0A, 4'd4, 8'd1, 4'd0, -1, 1'b0, "abort_restart");
    @(negedge clk);
    start = 1'b1; abort = 1'b1; pattern = 8'h0A; pat_len = 4'd4; repeat_n = 8'd1; gap = '0;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    n_tests++;
    if (obs() !== 5'b0) begin
      n_fail++;
      $display("FAIL start_abort_same: got %b expected 00000", obs());
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    pattern = 8'h0A; pat_len = 4'd4; repeat_n = 8'd3; gap = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_tests++;
    if ({t_valid, busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL pre_reset_active: got v,busy=%b expected 11", {t_valid, busy});
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (obs() !== 5'b0) begin
      n_fail++;
      $display("FAIL async_reset: got %b expected 00000", obs());
    end
    @(negedge clk); rst_n = 1'b1;
    run_xfer(8'h0A, 4'd4, 8'd1, 4'd0, -1, 1'b1, "after_reset");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int ab;
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 30)) : -1;
      run_xfer(8'($urandom), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 4)),
               4'($urandom_range(0, 3)), ab, 1'b1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_gap_repeat();
    test_loopback();
    test_boundaries();
    test_abort();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
